ysyx_24100005_register_file: RTL and testbench



---
 rtl/ysyx_24100005_pkg.sv | 6 +
 rtl/ysyx_24100005_dff_en.sv | 15 +
 rtl/ysyx_24100005_register_file.sv | 41 ++++
 tb/tb_ysyx_24100005_register_file.sv | 125 ++++++++++++
 4 files changed

// File: rtl/ysyx_24100005_pkg.sv
// ysyx_24100005_pkg: shared core constants (XLEN, register address width, zero register index).
package ysyx_24100005_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/ysyx_24100005_dff_en.sv
// ysyx_24100005_dff_en: enabled register with synchronous active-high reset to RESET_VAL.
module ysyx_24100005_dff_en #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  always_ff @(posedge clk)
    if (rst) dout <= RESET_VAL;
    else if (wen) dout <= din;
endmodule

// File: rtl/ysyx_24100005_register_file.sv
// ysyx_24100005_register_file: 2R1W integer register file, x0 hardwired to zero.
// Optional write-to-read forwarding with YSYX_24100005_RF_BYPASS_EN.
module ysyx_24100005_register_file
  import ysyx_24100005_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int DATA_WIDTH = XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] rs1addr,
  input  logic [ADDR_WIDTH-1:0] rs2addr,
  output logic [DATA_WIDTH-1:0] rs1data,
  output logic [DATA_WIDTH-1:0] rs2data
);
  localparam int NREGS = 1 << ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] w_regs [NREGS];
  assign w_regs[0] = '0;
  genvar i;
  for (i = 1; i < NREGS; i++) begin : g_reg
    ysyx_24100005_dff_en #(.WIDTH(DATA_WIDTH), .RESET_VAL('0)) u_reg (
      .clk (clk),
      .rst (rst),
      .wen (wen && (waddr == ADDR_WIDTH'(i))),
      .din (wdata),
      .dout(w_regs[i])
    );
  end
`ifdef YSYX_24100005_RF_BYPASS_EN
  logic w_fwd;
  assign w_fwd = wen && !rst && (waddr != ADDR_WIDTH'(ZERO_REG));
  assign rs1data = (w_fwd && rs1addr == waddr) ? wdata : w_regs[rs1addr];
  assign rs2data = (w_fwd && rs2addr == waddr) ? wdata : w_regs[rs2addr];
`else
  assign rs1data = w_regs[rs1addr];
  assign rs2data = w_regs[rs2addr];
`endif
endmodule

// File: tb/tb_ysyx_24100005_register_file.sv
// tb_ysyx_24100005_register_file: vector table, corner sequences and randomized model check.
module tb_ysyx_24100005_register_file;
  logic clk = 1'b0;
  logic rst, wen;
  logic [4:0] waddr, rs1addr, rs2addr;
  logic [31:0] wdata, rs1data, rs2data;
  int errors = 0;
  int checks = 0;
  logic [31:0] model [32];
`ifdef YSYX_24100005_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct {
    logic rst, wen;
    logic [4:0] waddr;
    logic [31:0] wdata;
    logic [4:0] rs1, rs2;
    logic [31:0] e1, e2;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  ysyx_24100005_register_file dut (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .rs1addr(rs1addr), .rs2addr(rs2addr), .rs1data(rs1data), .rs2data(rs2data)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (BYP && wen && !rst && waddr != 5'd0 && a == waddr) return wdata;
    return model[a];
  endfunction

  task automatic tick;
    if (rst) for (int k = 0; k < 32; k++) model[k] = 32'h0;
    else if (wen && waddr != 5'd0) model[waddr] = wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    #1;
    check({tag, "/rs1"}, rs1data, ref_rd(rs1addr));
    check({tag, "/rs2"}, rs2data, ref_rd(rs2addr));
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b1, 5'd3, 32'h1234_5678, 5'd3, 5'd0, 32'h0, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    tbl[2] = '{1'b0, 1'b0, 5'd7, 32'hA5A5_A5A5, 5'd7, 5'd6, 32'h0, 32'h0};
    tbl[3] = '{1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd5, 32'h0, 32'hDEAD_BEEF};
    tbl[4] = '{1'b0, 1'b1, 5'd9, 32'h0000_0001, 5'd9, 5'd0, 32'h1, 32'h0};
    tbl[5] = '{1'b0, 1'b1, 5'd5, 32'h0000_0000, 5'd5, 5'd9, 32'h0, 32'h1};
    rst = 1'b1; wen = 1'b1; waddr = 5'd3; wdata = 32'h1234_5678;
    rs1addr = 5'd0; rs2addr = 5'd0;
    tick();
    rst = 1'b0; wen = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rs1addr = 5'(a); rs2addr = 5'(31 - a);
      #1;
      check("reset_rs1", rs1data, 32'h0);
      check("reset_rs2", rs2data, 32'h0);
    end
    for (int v = 0; v < 6; v++) begin
      rst = tbl[v].rst; wen = tbl[v].wen; waddr = tbl[v].waddr; wdata = tbl[v].wdata;
      rs1addr = tbl[v].rs1; rs2addr = tbl[v].rs2;
      tick();
      check($sformatf("vec%0d_rs1", v), rs1data, tbl[v].e1);
      check($sformatf("vec%0d_rs2", v), rs2data, tbl[v].e2);
    end
    rst = 1'b0; wen = 1'b1; waddr = 5'd9; wdata = 32'h2; rs1addr = 5'd9; rs2addr = 5'd0;
    #1;
    check("rdw_pre", rs1data, BYP ? 32'h2 : 32'h1);
    tick();
    check("rdw_post", rs1data, 32'h2);
    wen = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; rs1addr = 5'd0; rs2addr = 5'd0;
    #1;
    check("x0_pre", rs1data, 32'h0);
    tick();
    check("x0_post", rs1data, 32'h0);
    for (int a = 1; a < 32; a++) begin
      wen = 1'b1; waddr = 5'(a); wdata = 32'h100 + 32'(a);
      tick();
    end
    wen = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rs1addr = 5'(a); rs2addr = 5'(31 - a);
      #1;
      check("sweep_rs1", rs1data, a == 0 ? 32'h0 : 32'h100 + 32'(a));
      check("sweep_rs2", rs2data, a == 31 ? 32'h0 : 32'h100 + 32'(31 - a));
    end
    rst = 1'b1; wen = 1'b1; waddr = 5'd5; wdata = 32'h5555_5555;
    tick();
    rst = 1'b0; wen = 1'b0;
    for (int a = 1; a < 32; a++) begin
      rs1addr = 5'(a);
      #1;
      check("midreset", rs1data, 32'h0);
    end
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      wen = 1'($urandom);
      waddr = 5'($urandom);
      wdata = $urandom;
      rs1addr = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
      rs2addr = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
      check_model("rand_pre");
      tick();
      check_model("rand_post");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
